envo_sched: RTL

ENVO_SCHED -- requirements
Module: envo_sched

---
 rtl/envo_sched_pkg.sv | 43 ++++
 rtl/envo_sched_gen_timer.sv | 41 ++++
 rtl/envo_sched.sv | 106 ++++++++++
 3 files changed

// File: rtl/envo_sched_pkg.sv
// rtl/envo_sched_pkg.sv - shared op codes, FSM encodings and helpers for envo_sched
package envo_sched_pkg;

    typedef enum logic [2:0] {
        OP_NONE     = 3'd0,
        OP_STEP     = 3'd1,
        OP_CLR      = 3'd2,
        OP_RANDOM   = 3'd3,
        OP_PATTERN  = 3'd4,
        OP_USER_SET = 3'd5
    } op_code_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    localparam logic [2:0] SPEED_RST = 3'd3;
    localparam logic [2:0] SPEED_MAX = 3'd7;

    // Pending vector layout: [0] STEP, [1] CLR, [2] RANDOM, [3] PATTERN, [4] USER_SET
    function automatic op_code_e pick_op(input logic [4:0] pend);
        if (pend[1])      return OP_CLR;
        else if (pend[2]) return OP_RANDOM;
        else if (pend[3]) return OP_PATTERN;
        else if (pend[4]) return OP_USER_SET;
        else if (pend[0]) return OP_STEP;
        else              return OP_NONE;
    endfunction

    function automatic logic [4:0] op_mask(input op_code_e op);
        case (op)
            OP_STEP:     return 5'b00001;
            OP_CLR:      return 5'b00010;
            OP_RANDOM:   return 5'b00100;
            OP_PATTERN:  return 5'b01000;
            OP_USER_SET: return 5'b10000;
            default:     return 5'b00000;
        endcase
    endfunction

endpackage

// File: rtl/envo_sched_gen_timer.sv
// rtl/envo_sched_gen_timer.sv - ms prescaler plus generation period counter
module envo_sched_gen_timer #(
    parameter int TICK_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] speed,
    input  logic       run,
    input  logic       reload,
    output logic       expire
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc;
    logic [9:0]    ms_cnt;
    logic [10:0]   period_m1;
    logic          tick_end;

    assign period_m1 = (11'd1024 >> speed) - 11'd1;
    assign tick_end  = (presc == PRESC_MAX);
    assign expire    = run && !reload && tick_end && ({1'b0, ms_cnt} == period_m1);

    // Counters sit at zero while paused so resuming always starts a full period
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc  <= '0;
            ms_cnt <= '0;
        end else if (!run || reload) begin
            presc  <= '0;
            ms_cnt <= '0;
        end else if (tick_end) begin
            presc  <= '0;
            ms_cnt <= expire ? 10'd0 : ms_cnt + 10'd1;
        end else begin
            presc  <= presc + PW'(1);
        end
    end

endmodule

// File: rtl/envo_sched.sv
// rtl/envo_sched.sv - generation scheduler issuing operations to the grid engine
module envo_sched
    import envo_sched_pkg::*;
#(
    parameter int TICK_DIV = 50000,
    parameter int GEN_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             cmd_clr,
    input  logic             cmd_random,
    input  logic             cmd_pattern,
    input  logic             cmd_user_set,
    input  logic             cmd_inc_v,
    input  logic             cmd_dec_v,
    input  logic             op_done,
    output logic             op_start,
    output logic [2:0]       op_code,
    output logic             busy,
    output logic [2:0]       speed,
    output logic [GEN_W-1:0] gen_count
);

    state_e     state, state_nxt;
    op_code_e   op_reg, sel;
    logic [5:0] cmd_now, cmd_q, rise;
    logic [4:0] pend, pend_set, issue_mask;
    logic [2:0] speed_q, speed_nxt;
    logic       expire, inc_e, dec_e, take, finish;

    assign cmd_now = {cmd_dec_v, cmd_inc_v, cmd_user_set, cmd_pattern, cmd_random, cmd_clr};
    assign rise    = cmd_now & ~cmd_q;
    assign inc_e   = rise[4];
    assign dec_e   = rise[5];

    always_comb begin
        speed_nxt = speed_q;
        if (inc_e && !dec_e && speed_q != SPEED_MAX)
            speed_nxt = speed_q + 3'd1;
        else if (dec_e && !inc_e && speed_q != 3'd0)
            speed_nxt = speed_q - 3'd1;
    end

    envo_sched_gen_timer #(.TICK_DIV(TICK_DIV)) u_gen_timer (
        .clk    (clk),
        .rst    (rst),
        .speed  (speed_q),
        .run    (mode),
        .reload (speed_nxt != speed_q),
        .expire (expire)
    );

    assign sel        = pick_op(pend);
    assign take       = (state == ST_IDLE) && (|pend);
    assign finish     = (state == ST_WAIT) && op_done;
    assign issue_mask = take ? op_mask(sel) : 5'b0;
    // User-set is an edit-mode key; it is meaningless while evolving
    assign pend_set   = {rise[3] & ~mode, rise[2], rise[1], rise[0], expire};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_q     <= '0;
            pend      <= '0;
            speed_q   <= SPEED_RST;
            op_reg    <= OP_NONE;
            gen_count <= '0;
        end else begin
            cmd_q   <= cmd_now;
            speed_q <= speed_nxt;
            pend    <= ((pend & ~issue_mask) | pend_set) & {4'b1111, mode};
            if (take)
                op_reg <= sel;
            else if (finish)
                op_reg <= OP_NONE;
            if (finish && op_reg == OP_STEP)
                gen_count <= gen_count + GEN_W'(1);
            else if (finish && op_reg == OP_CLR)
                gen_count <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (|pend) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (op_done) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        op_start = (state == ST_ISSUE);
        busy     = (state != ST_IDLE);
    end

    assign op_code = op_reg;
    assign speed   = speed_q;

endmodule
